// File: rtl/main_cpu_pkg.sv
// Shared types and constants for the main_cpu multi-cycle RV32I-subset core.
package main_cpu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned NREGS  = 32;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  typedef enum logic [1:0] {
    FETCH     = 2'd0,
    DECODE    = 2'd1,
    EXECUTE   = 2'd2,
    WRITEBACK = 2'd3
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_t;

  // alt is only honoured as SUB on register-register ops; ADDI has immediate bits there
  function automatic alu_op_t decode_alu_op(input logic [2:0] funct3, input logic alt,
                                            input logic is_reg);
    alu_op_t op;
    op = ALU_ADD;
    case (funct3)
      F3_ADD:  op = (alt && is_reg) ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      F3_AND:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  function automatic logic [XLEN-1:0] alu_exec(input alu_op_t op, input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    logic [XLEN-1:0] y;
    y = '0;
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_SLL:  y = a << b[4:0];
      ALU_SLT:  y = XLEN'($signed(a) < $signed(b));
      ALU_SLTU: y = XLEN'(a < b);
      ALU_XOR:  y = a ^ b;
      ALU_SRL:  y = a >> b[4:0];
      ALU_SRA:  y = XLEN'($signed(a) >>> b[4:0]);
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
      default:  y = '0;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/main_cpu_regfile.sv
// 32x32 register file: two async read ports, one sync write port, x0 fixed at zero.
module main_cpu_regfile
  import main_cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] raddr1,
  input  logic [REG_AW-1:0] raddr2,
  output logic [XLEN-1:0]   rdata1,
  output logic [XLEN-1:0]   rdata2,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [XLEN-1:0]   wdata
);

  logic [XLEN-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule

// File: rtl/main_cpu.sv
// Multi-cycle RV32I-subset core: FETCH/DECODE/EXECUTE/WRITEBACK, externally supplied instructions.
module main_cpu
  import main_cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] inst,
  input  logic [XLEN-1:0] in_bus,
  output logic [XLEN-1:0] out_bus
);

  state_t state, state_nxt;

  logic [XLEN-1:0] pc, ir;
  logic [XLEN-1:0] rs1_q, rs2_q, imm_q, result_q, next_pc_q;
  logic [XLEN-1:0] rs1_rd_c, rs2_rd_c, imm_c;
  logic [XLEN-1:0] alu_a_c, alu_b_c, alu_y_c, result_c, next_pc_c;
  alu_op_t         alu_op_c;
  logic            writes_c, store_c, taken_c, rf_we_c;

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [REG_AW-1:0] rd;

  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];
  assign rd     = ir[11:7];

  main_cpu_regfile u_regfile (
    .clk    (clk),
    .rst    (rst),
    .raddr1 (ir[19:15]),
    .raddr2 (ir[24:20]),
    .rdata1 (rs1_rd_c),
    .rdata2 (rs2_rd_c),
    .we     (rf_we_c),
    .waddr  (rd),
    .wdata  (result_q)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_nxt;
  end

  // Fixed four-step sequence; the register file is written only on the last step
  always_comb begin
    state_nxt = state;
    rf_we_c   = 1'b0;
    case (state)
      FETCH:     state_nxt = DECODE;
      DECODE:    state_nxt = EXECUTE;
      EXECUTE:   state_nxt = WRITEBACK;
      WRITEBACK: begin
        state_nxt = FETCH;
        rf_we_c   = writes_c && (rd != '0);
      end
      default:   state_nxt = FETCH;
    endcase
  end

  always_comb begin
    writes_c = 1'b0;
    store_c  = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_IMM, OP_REG, OP_LOAD: writes_c = 1'b1;
      OP_STORE: store_c = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    imm_c = {{20{ir[31]}}, ir[31:20]};
    case (opcode)
      OP_STORE:         imm_c = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      OP_BRANCH:        imm_c = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      OP_LUI, OP_AUIPC: imm_c = {ir[31:12], 12'b0};
      OP_JAL:           imm_c = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default: ;
    endcase
  end

  // Link value for jumps is produced by the ALU as pc + 4
  always_comb begin
    alu_op_c = ALU_ADD;
    alu_a_c  = rs1_q;
    alu_b_c  = imm_q;
    case (opcode)
      OP_LUI:   alu_a_c = '0;
      OP_AUIPC: alu_a_c = pc;
      OP_JAL, OP_JALR: begin
        alu_a_c = pc;
        alu_b_c = XLEN'(4);
      end
      OP_IMM:   alu_op_c = decode_alu_op(funct3, ir[30], 1'b0);
      OP_REG: begin
        alu_b_c  = rs2_q;
        alu_op_c = decode_alu_op(funct3, ir[30], 1'b1);
      end
      default: ;
    endcase
  end

  assign alu_y_c = alu_exec(alu_op_c, alu_a_c, alu_b_c);

  always_comb begin
    result_c = alu_y_c;
    case (opcode)
      OP_LOAD:  result_c = in_bus;
      OP_STORE: result_c = rs2_q;
      default: ;
    endcase
  end

  always_comb begin
    taken_c = 1'b0;
    case (funct3)
      F3_BEQ:  taken_c = (rs1_q == rs2_q);
      F3_BNE:  taken_c = (rs1_q != rs2_q);
      F3_BLT:  taken_c = ($signed(rs1_q) <  $signed(rs2_q));
      F3_BGE:  taken_c = ($signed(rs1_q) >= $signed(rs2_q));
      F3_BLTU: taken_c = (rs1_q <  rs2_q);
      F3_BGEU: taken_c = (rs1_q >= rs2_q);
      default: taken_c = 1'b0;
    endcase
  end

  always_comb begin
    next_pc_c = pc + XLEN'(4);
    case (opcode)
      OP_JAL:    next_pc_c = pc + imm_q;
      OP_JALR:   next_pc_c = (rs1_q + imm_q) & ~XLEN'(1);
      OP_BRANCH: if (taken_c) next_pc_c = pc + imm_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      ir        <= '0;
      out_bus   <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      imm_q     <= '0;
      result_q  <= '0;
      next_pc_q <= '0;
    end else begin
      case (state)
        FETCH:  ir <= inst;
        DECODE: begin
          rs1_q <= rs1_rd_c;
          rs2_q <= rs2_rd_c;
          imm_q <= imm_c;
        end
        EXECUTE: begin
          result_q  <= result_c;
          next_pc_q <= next_pc_c;
        end
        WRITEBACK: begin
          pc <= next_pc_q;
          if (writes_c || store_c) out_bus <= result_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_main_cpu.sv
// Randomized and directed bench for main_cpu against an instruction-level ISA model.
module tb_main_cpu;
  import main_cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst;
  logic [31:0] in_bus;
  logic [31:0] out_bus;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_pc;
  logic [31:0] m_out;

  main_cpu #(.RESET_PC(32'h0000_0000)) dut (
    .clk     (clk),
    .rst     (rst),
    .inst    (inst),
    .in_bus  (in_bus),
    .out_bus (out_bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] off, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], 7'b1100011};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_pc  = 32'h0;
    m_out = 32'h0;
  endtask

  // Architectural effect of one instruction, immediates rebuilt with signed shifts
  task automatic model_step(input logic [31:0] ins, input logic [31:0] bus);
    logic [31:0] a, b, y, res, npc;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        wr, st, take;
    a = m_regs[ins[19:15]];
    b = m_regs[ins[24:20]];
    imm_i = 32'($signed(ins) >>> 20);
    imm_s = (32'($signed(ins) >>> 25) << 5) | 32'(ins[11:7]);
    imm_b = (32'($signed(ins) >>> 31) << 12) | (32'(ins[7]) << 11) |
            (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
    imm_u = ins & 32'hFFFF_F000;
    imm_j = (32'($signed(ins) >>> 31) << 20) | (32'(ins[19:12]) << 12) |
            (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
    npc = m_pc + 32'd4;
    res = 32'h0; wr = 1'b0; st = 1'b0; take = 1'b0;
    case (ins[6:0])
      7'b0110111: begin wr = 1'b1; res = imm_u; end
      7'b0010111: begin wr = 1'b1; res = m_pc + imm_u; end
      7'b1101111: begin wr = 1'b1; res = m_pc + 32'd4; npc = m_pc + imm_j; end
      7'b1100111: begin wr = 1'b1; res = m_pc + 32'd4; npc = (a + imm_i) & 32'hFFFF_FFFE; end
      7'b1100011: begin
        case (ins[14:12])
          3'd0: take = (a == b);
          3'd1: take = (a != b);
          3'd4: take = ($signed(a) <  $signed(b));
          3'd5: take = ($signed(a) >= $signed(b));
          3'd6: take = (a <  b);
          3'd7: take = (a >= b);
          default: take = 1'b0;
        endcase
        if (take) npc = m_pc + imm_b;
      end
      7'b0010011, 7'b0110011: begin
        wr = 1'b1;
        y = (ins[6:0] == 7'b0110011) ? b : imm_i;
        case (ins[14:12])
          3'd0: res = (ins[6:0] == 7'b0110011 && ins[30]) ? a - y : a + y;
          3'd1: res = a << y[4:0];
          3'd2: res = ($signed(a) < $signed(y)) ? 32'd1 : 32'd0;
          3'd3: res = (a < y) ? 32'd1 : 32'd0;
          3'd4: res = a ^ y;
          3'd5: res = ins[30] ? 32'($signed(a) >>> y[4:0]) : a >> y[4:0];
          3'd6: res = a | y;
          default: res = a & y;
        endcase
      end
      7'b0000011: begin wr = 1'b1; res = bus; end
      7'b0100011: st = 1'b1;
      default: ;
    endcase
    if (wr) begin
      if (ins[11:7] != 5'd0) m_regs[ins[11:7]] = res;
      m_out = res;
    end
    if (st) m_out = b;
    m_pc = npc;
  endtask

  // Present one instruction for the full four-cycle sequence, then sample 1ns after the edge
  task automatic run_inst(input logic [31:0] ins, input logic [31:0] bus);
    inst   = ins;
    in_bus = bus;
    repeat (4) @(posedge clk);
    #1;
    model_step(ins, bus);
  endtask

  task automatic test_reset();
    rst = 1'b1; inst = 32'h0; in_bus = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    total++;
    if (out_bus !== 32'h0) begin bad++; $display("FAIL reset_out: got %h want %h", out_bus, 32'h0); end
    total++;
    if (dut.pc !== 32'h0) begin bad++; $display("FAIL reset_pc: got %h want %h", dut.pc, 32'h0); end
    total++;
    if (dut.state !== FETCH) begin bad++; $display("FAIL reset_state: got %0d want %0d", dut.state, FETCH); end
  endtask

  task automatic test_upper_jump();
    run_inst(32'h0000_0000, 32'hDEAD_BEEF);
    total++;
    if (dut.pc !== 32'h4) begin bad++; $display("FAIL nop_pc: got %h want %h", dut.pc, 32'h4); end
    total++;
    if (out_bus !== 32'h0) begin bad++; $display("FAIL nop_out: got %h want %h", out_bus, 32'h0); end
    run_inst({20'h1234A, 5'd1, 7'b0110111}, 32'h0);
    total++;
    if (out_bus !== 32'h1234_A000) begin bad++; $display("FAIL lui_out: got %h want %h", out_bus, 32'h1234_A000); end
    total++;
    if (dut.pc !== 32'h8) begin bad++; $display("FAIL lui_pc: got %h want %h", dut.pc, 32'h8); end
    run_inst({20'h22222, 5'd1, 7'b0010111}, 32'h0);
    total++;
    if (out_bus !== 32'h2222_2008) begin bad++; $display("FAIL auipc_out: got %h want %h", out_bus, 32'h2222_2008); end
    run_inst({20'h22222, 5'd1, 7'b1101111}, 32'h0);
    total++;
    if (out_bus !== 32'h10) begin bad++; $display("FAIL jal_out: got %h want %h", out_bus, 32'h10); end
    total++;
    if (dut.pc !== 32'h0002_222E) begin bad++; $display("FAIL jal_pc: got %h want %h", dut.pc, 32'h0002_222E); end
    run_inst(enc_s(12'h0, 5'd1, 5'd0, 3'd2), 32'h0);
    total++;
    if (out_bus !== 32'h10) begin bad++; $display("FAIL jal_link_reg: got %h want %h", out_bus, 32'h10); end
  endtask

  task automatic test_datapath();
    run_inst(enc_i(12'hFFF, 5'd0, 3'd0, 5'd2, 7'b0010011), 32'h0);
    total++;
    if (out_bus !== 32'hFFFF_FFFF) begin bad++; $display("FAIL addi_neg: got %h want %h", out_bus, 32'hFFFF_FFFF); end
    run_inst(enc_i(12'h404, 5'd2, 3'd5, 5'd3, 7'b0010011), 32'h0);
    total++;
    if (out_bus !== 32'hFFFF_FFFF) begin bad++; $display("FAIL srai: got %h want %h", out_bus, 32'hFFFF_FFFF); end
    run_inst(enc_i(12'h004, 5'd2, 3'd5, 5'd3, 7'b0010011), 32'h0);
    total++;
    if (out_bus !== 32'h0FFF_FFFF) begin bad++; $display("FAIL srli: got %h want %h", out_bus, 32'h0FFF_FFFF); end
    run_inst(enc_i(12'h000, 5'd0, 3'd2, 5'd4, 7'b0000011), 32'd58);
    total++;
    if (out_bus !== 32'd58) begin bad++; $display("FAIL lw: got %h want %h", out_bus, 32'd58); end
    run_inst(enc_s(12'h0, 5'd4, 5'd0, 3'd2), 32'h1111_1111);
    total++;
    if (out_bus !== 32'd58) begin bad++; $display("FAIL sw: got %h want %h", out_bus, 32'd58); end
    run_inst(enc_i(12'h005, 5'd0, 3'd0, 5'd0, 7'b0010011), 32'h0);
    total++;
    if (out_bus !== 32'd5) begin bad++; $display("FAIL addi_x0_out: got %h want %h", out_bus, 32'd5); end
    run_inst(enc_s(12'h0, 5'd0, 5'd0, 3'd2), 32'h0);
    total++;
    if (out_bus !== 32'h0) begin bad++; $display("FAIL x0_reads_zero: got %h want %h", out_bus, 32'h0); end
    total++;
    if (dut.pc !== m_pc) begin bad++; $display("FAIL datapath_pc: got %h want %h", dut.pc, m_pc); end
  endtask

  task automatic test_branch();
    logic [31:0] p;
    logic [31:0] hold;
    p = m_pc; hold = m_out;
    run_inst(enc_b(13'd8, 5'd0, 5'd0, 3'd0), 32'h0);
    total++;
    if (dut.pc !== p + 32'd8) begin bad++; $display("FAIL beq_taken: got %h want %h", dut.pc, p + 32'd8); end
    total++;
    if (out_bus !== hold) begin bad++; $display("FAIL branch_holds_out: got %h want %h", out_bus, hold); end
    p = m_pc;
    run_inst(enc_b(13'd8, 5'd0, 5'd0, 3'd1), 32'h0);
    total++;
    if (dut.pc !== p + 32'd4) begin bad++; $display("FAIL bne_not_taken: got %h want %h", dut.pc, p + 32'd4); end
  endtask

  task automatic test_reset_mid();
    inst = enc_i(12'h007, 5'd0, 3'd0, 5'd5, 7'b0010011);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    total++;
    if (dut.state !== FETCH) begin bad++; $display("FAIL rst_mid_state: got %0d want %0d", dut.state, FETCH); end
    total++;
    if (dut.pc !== 32'h0) begin bad++; $display("FAIL rst_mid_pc: got %h want %h", dut.pc, 32'h0); end
    total++;
    if (out_bus !== 32'h0) begin bad++; $display("FAIL rst_mid_out: got %h want %h", out_bus, 32'h0); end
    run_inst(enc_s(12'h0, 5'd5, 5'd0, 3'd2), 32'h0);
    total++;
    if (out_bus !== 32'h0) begin bad++; $display("FAIL rst_mid_no_wb: got %h want %h", out_bus, 32'h0); end
    total++;
    if (dut.pc !== 32'h4) begin bad++; $display("FAIL rst_mid_restart_pc: got %h want %h", dut.pc, 32'h4); end
  endtask

  task automatic test_random(input int n);
    logic [31:0] r, ins;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  br_f3 [6];
    br_f3 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    for (int k = 0; k < n; k++) begin
      r   = $urandom;
      rd  = 5'($urandom_range(0, 31));
      rs1 = 5'($urandom_range(0, 31));
      rs2 = 5'($urandom_range(0, 31));
      f3  = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 9))
        0: ins = {r[19:0], rd, 7'b0110111};
        1: ins = {r[19:0], rd, 7'b0010111};
        2: ins = {r[19:0], rd, 7'b1101111};
        3: ins = enc_i(r[11:0], rs1, 3'd0, rd, 7'b1100111);
        4: ins = enc_b({r[12:1], 1'b0}, rs2, rs1, br_f3[$urandom_range(0, 5)]);
        5: begin
          if (f3 == 3'd1)      ins = enc_i({7'd0, r[4:0]}, rs1, f3, rd, 7'b0010011);
          else if (f3 == 3'd5) ins = enc_i({1'b0, r[5], 5'd0, r[4:0]}, rs1, f3, rd, 7'b0010011);
          else                 ins = enc_i(r[11:0], rs1, f3, rd, 7'b0010011);
        end
        6: begin
          if (f3 == 3'd0 || f3 == 3'd5) ins = {1'b0, r[5], 5'd0, rs2, rs1, f3, rd, 7'b0110011};
          else                          ins = {7'd0, rs2, rs1, f3, rd, 7'b0110011};
        end
        7: ins = enc_i(r[11:0], rs1, f3, rd, 7'b0000011);
        8: ins = enc_s(r[11:0], rs2, rs1, 3'd2);
        default: ins = r[0] ? 32'h0 : {r[31:7], 7'b0001111};
      endcase
      run_inst(ins, $urandom);
      total++;
      if (out_bus !== m_out) begin
        bad++; $display("FAIL rand_out[%0d] ins=%h: got %h want %h", k, ins, out_bus, m_out);
      end
      total++;
      if (dut.pc !== m_pc) begin
        bad++; $display("FAIL rand_pc[%0d] ins=%h: got %h want %h", k, ins, dut.pc, m_pc);
      end
    end
  endtask

  // Store every register once so the whole file is observed through out_bus
  task automatic test_regdump();
    for (int i = 0; i < 32; i++) begin
      run_inst(enc_s(12'h0, 5'(i), 5'd0, 3'd2), 32'h0);
      total++;
      if (out_bus !== m_regs[i]) begin
        bad++; $display("FAIL regdump x%0d: got %h want %h", i, out_bus, m_regs[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_upper_jump();
    test_datapath();
    test_branch();
    test_random(150);
    test_regdump();
    test_reset_mid();
    test_random(150);
    test_regdump();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/main_cpu.md
Name: main_cpu

Overview:
- Minimal multi-cycle RV32I-subset CPU core.
- Instructions arrive on `inst` from an external source; the core has no instruction memory.
- Each instruction takes a fixed 4-cycle FSM: FETCH, DECODE, EXECUTE, WRITEBACK.
- Holds the PC and a 32x32 register file. `in_bus` supplies load data; `out_bus` presents results and store data.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising-edge active.
- rst  in  1  synchronous, active-high reset.
- inst  in  32  instruction word, sampled only in FETCH.
- in_bus  in  32  external data input, returned by loads.
- out_bus  out  32  registered output: last writeback result or store data.

Behaviour:
- One clock (`clk`); reset is synchronous and active-high (`rst`).
- Reset (`rst`=1 at posedge):
  - state=FETCH, PC=RESET_PC, IR=0, out_bus=0.
  - All registers x1..x31 cleared to 0.
- State sequence: FETCH -> DECODE -> EXECUTE -> WRITEBACK -> FETCH, one state per cycle, unconditional.
  - A reset asserted in any state aborts the instruction: no writeback, no PC update.
- FETCH: IR <= inst.
- DECODE:
  - Read rs1=IR[19:15], rs2=IR[24:20] from the register file.
  - Form the immediate by type: I, S, B, U, J, per the RV32I spec, sign-extended.
- EXECUTE: ALU computes the result and the next PC (default PC+4), both registered.
- WRITEBACK:
  - Write rd=IR[11:7] if the instruction writes back and rd!=0.
  - Update PC; update out_bus.
- x0 always reads 0; writes to x0 are discarded.
- Supported opcodes:
  - LUI 0110111: rd=imm_u.
  - AUIPC 0010111: rd=PC+imm_u.
  - JAL 1101111: rd=PC+4; PC=PC+imm_j.
  - JALR 1100111: rd=PC+4; PC=(rs1+imm_i)&~1.
  - BRANCH 1100011: BEQ, BNE, BLT, BGE, BLTU, BGEU. If taken PC=PC+imm_b, else PC+4. No writeback.
  - OP-IMM 0010011: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI. Shamt=imm[4:0]; IR[30] selects SRA.
  - OP 0110011: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND. IR[30] selects SUB/SRA.
  - LOAD 0000011: rd=in_bus, for every funct3. No address bus; the address is computed but unused.
  - STORE 0100011: out_bus=rs2 value; no rd write.
- Any other opcode, including 0x00000000: NOP. PC+=4; no register or out_bus change.
- out_bus:
  - Writeback instructions (including rd=x0): out_bus=result in WRITEBACK.
  - STORE: out_bus=rs2 value.
  - Branches and NOPs: out_bus holds.
- Arithmetic wraps modulo 2^32; no traps, no misalignment checks. PC wraps at 2^32.
- The PC register holds the address of the current instruction; it is updated only in WRITEBACK.

Decomposition:
- Package main_cpu_pkg: opcode constants, funct3 constants, state enum (FETCH/DECODE/EXECUTE/WRITEBACK), ALU-op enum.
- Sub-module main_cpu_regfile: 32x32, 2 async read ports, 1 sync write port, x0 hardwired to 0, synchronous clear on rst.
- ALU and immediate generation stay in the top module.

Test Plan:
- Reset, then inst=0x00000000 held 4 cycles -> PC 0 -> 4; out_bus stays 0.
- At PC=4, inst={20'h1234A,5'd1,7'b0110111} (LUI x1) -> after WRITEBACK x1=out_bus=0x1234A000; PC=8.
- At PC=8, inst={20'h22222,5'd1,7'b0010111} (AUIPC x1) -> x1=out_bus=0x22222008; PC=0xC.
- At PC=0xC, inst={20'h22222,5'd1,7'b1101111} (JAL x1) -> x1=out_bus=0x10; PC=0x2222E.
- Arithmetic and data path:
  - ADDI x2,x0,-1 -> x2=0xFFFFFFFF.
  - SRAI x3,x2,4 -> 0xFFFFFFFF; SRLI -> 0x0FFFFFFF.
  - LW x4 with in_bus=58 -> x4=out_bus=58.
  - SW x4 -> out_bus=58.
  - ADDI x0,x0,5 -> x0 reads 0.
- Branch and reset:
  - BEQ x0,x0,+8 at PC=P -> PC=P+8; BNE x0,x0 -> PC=P+4.
  - rst asserted in EXECUTE -> next state FETCH, PC=0, out_bus=0, no writeback.
